bus_rr_scheduler: RTL and testbench

//  Round-robin scheduler for the shared data bus between DRVRS driver-side FIFOs
//  and DRVRS destination FIFOs.
//  - Grants one pending source, pops one packet, decodes its destination ID,

---
 rtl/bus_sched_pkg.sv | 28 ++
 rtl/bus_rr_scheduler_rr_pick.sv | 30 +++
 rtl/bus_rr_scheduler.sv | 107 ++++++++++
 tb/tb_bus_rr_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sched_pkg.sv
// Shared types and destination decode for the round-robin bus scheduler.
// Mask is computed at a fixed maximum width; callers truncate to their port count.
package bus_sched_pkg;

   typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BROADCAST = 8'hFF;
   localparam int MAX_DRVRS = 32;
   localparam int MAX_IW = $clog2(MAX_DRVRS);

   function automatic logic [MAX_DRVRS-1:0] dest_mask(
      input logic [ID_W-1:0] id,
      input int src,
      input int n
   );
      logic [MAX_DRVRS-1:0] m;
      m = '0;
      if (id == BROADCAST) begin
         for (int i = 0; i < MAX_DRVRS; i++)
            if (i < n && i != src) m[i] = 1'b1;
      end else if (int'(id) < n) begin
         m[id[MAX_IW-1:0]] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/bus_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
   parameter int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt_idx,
   output logic         any
);

   always_comb begin
      int idx;
      logic found;
      idx = 0;
      found = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found = 1'b1;
            gnt_idx = idx[W-1:0];
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler moving one packet at a time from source FIFOs
// to one or all destination FIFOs (IDLE -> POP -> PUSH).
module bus_rr_scheduler
   import bus_sched_pkg::*;
#(
   parameter int DRVRS = 4,
   parameter int PCKG_SZ = 16,
   localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DRVRS-1:0]                pndng,
   input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
   output logic [DRVRS-1:0]                pop,
   input  logic [DRVRS-1:0]                full,
   output logic [DRVRS-1:0]                push,
   output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
   output logic                            busy,
   output logic [GW-1:0]                   grant,
   output logic [15:0]                     drop_cnt
);

   state_t               state, state_n;
   logic [GW-1:0]        rr_ptr, rr_n, grant_n, pick;
   logic [PCKG_SZ-1:0]   pkt, pkt_n, dq, d_n, cur;
   logic [DRVRS-1:0]     pop_n, push_n, mask;
   logic [15:0]          drop_n;
   logic                 any, blocked;

   rr_pick #(.N(DRVRS)) u_pick (
      .req     (pndng),
      .ptr     (rr_ptr),
      .gnt_idx (pick),
      .any     (any)
   );

   // In POP the packet is not latched yet, so decode straight from the FIFO head.
   always_comb begin
      cur = (state == POP) ? D_pop[grant] : pkt;
      mask = DRVRS'(dest_mask(cur[PCKG_SZ-1 -: ID_W], int'(grant), DRVRS));
      blocked = |(mask & full);
   end

   always_comb begin
      state_n = state;
      rr_n    = rr_ptr;
      grant_n = grant;
      pkt_n   = pkt;
      d_n     = dq;
      pop_n   = '0;
      push_n  = '0;
      drop_n  = drop_cnt;
      unique case (state)
         IDLE: begin
            if (any) begin
               grant_n = pick;
               pop_n[pick] = 1'b1;
               state_n = POP;
            end
         end
         POP: begin
            pkt_n = cur;
            d_n = cur;
            rr_n = (grant == GW'(DRVRS-1)) ? '0 : grant + 1'b1;
            state_n = PUSH;
            if (mask != '0 && !blocked) push_n = mask;
         end
         PUSH: begin
            if (push != '0) begin
               state_n = IDLE;
            end else if (mask == '0) begin
               state_n = IDLE;
               if (drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
            end else if (!blocked) begin
               push_n = mask;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         pkt      <= '0;
         dq       <= '0;
         pop      <= '0;
         push     <= '0;
         drop_cnt <= '0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_n;
         grant    <= grant_n;
         pkt      <= pkt_n;
         dq       <= d_n;
         pop      <= pop_n;
         push     <= push_n;
         drop_cnt <= drop_n;
      end
   end

   assign busy = (state != IDLE);
   assign D_push = {DRVRS{dq}};

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Self-checking bench for bus_rr_scheduler: directed scenarios plus a
// randomized run against a FIFO/scoreboard reference model.
module tb_bus_rr_scheduler;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [3:0]       pndng = '0;
   logic [3:0][15:0] D_pop = '0;
   logic [3:0]       pop;
   logic [3:0]       full = '0;
   logic [3:0]       push;
   logic [3:0][15:0] D_push;
   logic             busy;
   logic [1:0]       grant;
   logic [15:0]      drop_cnt;

   int checks = 0;
   int errors = 0;

   logic [15:0] srcq [4][$];
   logic [3:0]  im_q [$];
   logic [15:0] id_q [$];

   bus_rr_scheduler #(.DRVRS(4), .PCKG_SZ(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .pndng    (pndng),
      .D_pop    (D_pop),
      .pop      (pop),
      .full     (full),
      .push     (push),
      .D_push   (D_push),
      .busy     (busy),
      .grant    (grant),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   function automatic int exp_rr(logic [3:0] p, int ptr);
      for (int k = 0; k < 4; k++)
         if (p[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] exp_mask(logic [7:0] id, int src);
      if (id == 8'hFF) return 4'hF & ~(4'b0001 << src);
      if (id < 8'd4) return 4'b0001 << id;
      return 4'b0000;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      pndng = '0;
      full = '0;
      D_pop = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({pop, push, D_push, busy, grant, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state: pop=%b push=%b dpush=%h busy=%b grant=%0d drop=%0d exp all 0",
                  pop, push, D_push, busy, grant, drop_cnt);
      end
   endtask

   task automatic test_single();
      apply_reset();
      D_pop[1] = 16'h02AB;
      pndng = 4'b0010;
      tick();
      checks++;
      if (pop !== 4'b0010 || push !== 4'b0000 || grant !== 2'd1) begin
         errors++;
         $display("FAIL single_pop: pop=%b push=%b grant=%0d exp pop=0010 push=0000 grant=1",
                  pop, push, grant);
      end
      pndng = 4'b0000;
      tick();
      checks++;
      if (push !== 4'b0100 || pop !== 4'b0000 || D_push[2] !== 16'h02AB) begin
         errors++;
         $display("FAIL single_push: push=%b pop=%b d=%h exp push=0100 pop=0000 d=02ab",
                  push, pop, D_push[2]);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || push !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle: busy=%b push=%b exp busy=0 push=0000", busy, push);
      end
   endtask

   task automatic test_rr_order();
      apply_reset();
      for (int i = 0; i < 4; i++) D_pop[i] = {8'(i), 8'hA0 + 8'(i)};
      pndng = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         tick();
         checks++;
         if (pop !== (4'b0001 << (j % 4)) || grant !== 2'(j % 4)) begin
            errors++;
            $display("FAIL rr_order[%0d]: pop=%b grant=%0d exp pop=%b grant=%0d",
                     j, pop, grant, 4'b0001 << (j % 4), j % 4);
         end
         if (j < 4) begin
            for (int t = 0; t < 2; t++) begin
               tick();
               checks++;
               if (pop !== 4'b0000) begin
                  errors++;
                  $display("FAIL rr_gap[%0d.%0d]: pop=%b exp 0000", j, t, pop);
               end
            end
         end
      end
      pndng = 4'b0000;
      tick();
      tick();
   endtask

   task automatic test_broadcast_stall();
      apply_reset();
      D_pop[3] = 16'hFF5A;
      pndng = 4'b1000;
      full = 4'b0001;
      tick();
      checks++;
      if (pop !== 4'b1000) begin
         errors++;
         $display("FAIL bc_pop: pop=%b exp 1000", pop);
      end
      pndng = 4'b0000;
      for (int t = 0; t < 5; t++) begin
         tick();
         checks++;
         if (push !== 4'b0000 || busy !== 1'b1 || D_push[0] !== 16'hFF5A) begin
            errors++;
            $display("FAIL bc_stall[%0d]: push=%b busy=%b d=%h exp push=0000 busy=1 d=ff5a",
                     t, push, busy, D_push[0]);
         end
      end
      full = 4'b0000;
      tick();
      checks++;
      if (push !== 4'b0111 || D_push !== {4{16'hFF5A}}) begin
         errors++;
         $display("FAIL bc_push: push=%b d=%h exp push=0111 d=ff5a x4", push, D_push);
      end
      tick();
      checks++;
      if (push !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bc_once: push=%b busy=%b exp push=0000 busy=0", push, busy);
      end
   endtask

   task automatic test_drop();
      apply_reset();
      D_pop[0] = 16'h0711;
      D_pop[1] = 16'h0122;
      pndng = 4'b0011;
      tick();
      checks++;
      if (pop !== 4'b0001) begin
         errors++;
         $display("FAIL drop_pop: pop=%b exp 0001", pop);
      end
      pndng = 4'b0010;
      tick();
      tick();
      checks++;
      if (push !== 4'b0000 || busy !== 1'b0 || drop_cnt !== 16'd1) begin
         errors++;
         $display("FAIL drop_cnt: push=%b busy=%b drop=%0d exp push=0000 busy=0 drop=1",
                  push, busy, drop_cnt);
      end
      tick();
      checks++;
      if (pop !== 4'b0010 || grant !== 2'd1) begin
         errors++;
         $display("FAIL drop_next: pop=%b grant=%0d exp pop=0010 grant=1", pop, grant);
      end
      pndng = 4'b0000;
      tick();
      checks++;
      if (push !== 4'b0010 || D_push[1] !== 16'h0122) begin
         errors++;
         $display("FAIL drop_next_push: push=%b d=%h exp push=0010 d=0122", push, D_push[1]);
      end
      tick();
   endtask

   task automatic test_reset_mid_push();
      D_pop[0] = 16'h0211;
      pndng = 4'b0001;
      full = 4'b0100;
      tick();
      pndng = 4'b0000;
      tick();
      tick();
      checks++;
      if (busy !== 1'b1 || push !== 4'b0000 || drop_cnt === 16'd0) begin
         errors++;
         $display("FAIL midrst_setup: busy=%b push=%b drop=%0d exp busy=1 push=0000 drop>0",
                  busy, push, drop_cnt);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({pop, push, D_push, busy, grant, drop_cnt} !== '0) begin
         errors++;
         $display("FAIL midrst_async: pop=%b push=%b d=%h busy=%b grant=%0d drop=%0d exp all 0",
                  pop, push, D_push, busy, grant, drop_cnt);
      end
      tick();
      reset = 1'b0;
      full = 4'b0000;
      for (int t = 0; t < 3; t++) begin
         tick();
         checks++;
         if (push !== 4'b0000 || pop !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_lost[%0d]: push=%b pop=%b busy=%b exp 0000 0000 0",
                     t, push, pop, busy);
         end
      end
   endtask

   task automatic test_self();
      apply_reset();
      D_pop[2] = 16'h0233;
      pndng = 4'b0100;
      tick();
      pndng = 4'b0000;
      tick();
      checks++;
      if (push !== 4'b0100 || D_push[2] !== 16'h0233) begin
         errors++;
         $display("FAIL self_push: push=%b d=%h exp push=0100 d=0233", push, D_push[2]);
      end
      tick();
   endtask

   task automatic test_random();
      logic [7:0] ids [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h07, 8'h40};
      logic [3:0] prev_pndng, prev_full, m;
      logic [15:0] p;
      int exp_ptr, exp_drop, pend, s, e;
      apply_reset();
      for (int i = 0; i < 4; i++) srcq[i].delete();
      im_q.delete();
      id_q.delete();
      prev_pndng = '0;
      prev_full = '0;
      exp_ptr = 0;
      exp_drop = 0;
      pend = -1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         s = -1;
         if ((pop & push) != 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL rnd_overlap: pop=%b push=%b exp disjoint", pop, push);
         end
         if (pop != 4'b0000) begin
            for (int i = 3; i >= 0; i--) if (pop[i]) s = i;
            e = exp_rr(prev_pndng, exp_ptr);
            checks++;
            if ($countones(pop) != 1 || s != e || srcq[s].size() == 0) begin
               errors++;
               $display("FAIL rnd_grant: pop=%b exp src %0d", pop, e);
            end else begin
               p = srcq[s][0];
               m = exp_mask(p[15:8], s);
               if (m == 4'b0000) exp_drop++;
               else begin
                  im_q.push_back(m);
                  id_q.push_back(p);
               end
            end
            exp_ptr = (s + 1) % 4;
         end
         if (push != 4'b0000) begin
            checks++;
            if (im_q.size() == 0) begin
               errors++;
               $display("FAIL rnd_push_spurious: push=%b exp none", push);
            end else begin
               if (push !== im_q[0] || D_push !== {4{id_q[0]}} ||
                   (push & prev_full) != 4'b0000) begin
                  errors++;
                  $display("FAIL rnd_push: push=%b d=%h full=%b exp push=%b d=%h",
                           push, D_push, prev_full, im_q[0], id_q[0]);
               end
               void'(im_q.pop_front());
               void'(id_q.pop_front());
            end
         end
         if (!busy) begin
            checks++;
            if (drop_cnt !== 16'(exp_drop) || im_q.size() != 0) begin
               errors++;
               $display("FAIL rnd_idle: drop=%0d pending=%0d exp drop=%0d pending=0",
                        drop_cnt, im_q.size(), exp_drop);
            end
         end
         if (pend >= 0) void'(srcq[pend].pop_front());
         pend = s;
         if (cyc < 2500 && $urandom_range(0, 2) == 0) begin
            e = $urandom_range(0, 3);
            if (srcq[e].size() < 4)
               srcq[e].push_back({ids[$urandom_range(0, 7)], 8'($urandom)});
         end
         full = (cyc < 2500 && $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         for (int i = 0; i < 4; i++) begin
            pndng[i] = (srcq[i].size() != 0);
            D_pop[i] = (srcq[i].size() != 0) ? srcq[i][0] : 16'h0000;
         end
         prev_pndng = pndng;
         prev_full = full;
      end
      checks++;
      if (busy !== 1'b0 || im_q.size() != 0 || drop_cnt !== 16'(exp_drop) ||
          srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() != 0) begin
         errors++;
         $display("FAIL rnd_drain: busy=%b pending=%0d drop=%0d exp busy=0 pending=0 drop=%0d",
                  busy, im_q.size(), drop_cnt, exp_drop);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_order();
      test_broadcast_stall();
      test_drop();
      test_reset_mid_push();
      test_self();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
